// File: rtl/bitstream_pkg.sv
// Shared types for the bit-stream detector datapath: arbiter FSM states and the beat record.
package bitstream_pkg;

  localparam int MAX_SRC = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic sop;
    logic eop;
    logic data;
  } beat_t;

endpackage

// File: rtl/bitstream_pkt_arbiter_if.sv
// Source-side and detector-side stream bundle of the packet arbiter.
interface bitstream_pkt_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int CH_W  = $clog2(N_SRC)
);
  logic [N_SRC-1:0] s_valid;
  logic [N_SRC-1:0] s_sop;
  logic [N_SRC-1:0] s_eop;
  logic [N_SRC-1:0] s_data;
  logic [N_SRC-1:0] s_ready;
  logic             m_ready;
  logic             m_valid;
  logic             m_sop;
  logic             m_eop;
  logic             m_data;
  logic [CH_W-1:0]  m_chan;
  logic             err_orphan;
  logic             err_sop;

  // master: sources plus downstream detector; slave: the arbiter
  modport master (
    output s_valid, s_sop, s_eop, s_data, m_ready,
    input  s_ready, m_valid, m_sop, m_eop, m_data, m_chan, err_orphan, err_sop
  );

  modport slave (
    input  s_valid, s_sop, s_eop, s_data, m_ready,
    output s_ready, m_valid, m_sop, m_eop, m_data, m_chan, err_orphan, err_sop
  );
endinterface

// File: rtl/bitstream_pkt_arbiter_rr_pick.sv
// Round-robin priority search: first set request at or above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  always_comb begin
    logic [W:0] j;
    idx_o   = '0;
    found_o = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      // one spare bit so ptr+k cannot overflow before the wrap
      j = {1'b0, ptr_i} + (W+1)'(k);
      if (j >= (W+1)'(N)) j = j - (W+1)'(N);
      if (!found_o && req_i[j[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/bitstream_pkt_arbiter.sv
// Packet-locked round-robin arbiter feeding one shared single-bit detector pipeline.
module bitstream_pkt_arbiter
  import bitstream_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int CH_W  = $clog2(N_SRC)
) (
  input logic                    clk,
  input logic                    reset_n,
  bitstream_pkt_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_LOCK = LOCK;

  logic [0:0]       state_q, state_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]  chan_q, chan_d;
  beat_t            beat_q, beat_d;
  logic             m_valid_q, m_valid_d;
  logic             first_q, first_d;
  logic             err_orphan_q, err_orphan_d;
  logic             err_sop_q, err_sop_d;

  logic [N_SRC-1:0] s_ready;
  logic [N_SRC-1:0] sop_req;
  logic [CH_W-1:0]  pick_idx;
  logic             pick_found;
  logic             xfer;

  assign sop_req = bus.s_valid & bus.s_sop;

  rr_pick #(.N(N_SRC), .W(CH_W)) u_pick (
    .req_i   (sop_req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Orphans drain freely in IDLE so a source can never wedge; the winner waits a cycle.
  always_comb begin
    s_ready = '0;
    if (reset_n) begin
      if (state_q == S_IDLE) s_ready = bus.s_valid & ~bus.s_sop;
      else                   s_ready[grant_q] = !m_valid_q || bus.m_ready;
    end
  end

  assign xfer = (state_q == S_LOCK) && bus.s_valid[grant_q] && s_ready[grant_q];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    chan_d       = chan_q;
    beat_d       = beat_q;
    m_valid_d    = m_valid_q;
    first_d      = first_q;
    err_orphan_d = 1'b0;
    err_sop_d    = 1'b0;

    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;

    if (state_q == S_IDLE) begin
      err_orphan_d = |(bus.s_valid & ~bus.s_sop);
      if (pick_found) begin
        grant_d = pick_idx;
        state_d = S_LOCK;
        first_d = 1'b1;
      end
    end else if (xfer) begin
      beat_d.sop = bus.s_sop[grant_q];
      beat_d.eop = bus.s_eop[grant_q];
      beat_d.data = bus.s_data[grant_q];
      chan_d     = grant_q;
      m_valid_d  = 1'b1;
      first_d    = 1'b0;
      // a repeated sop is passed through; only eop releases the lock
      err_sop_d  = bus.s_sop[grant_q] && !first_q;
      if (bus.s_eop[grant_q]) begin
        state_d  = S_IDLE;
        rr_ptr_d = (grant_q == CH_W'(N_SRC-1)) ? '0 : grant_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      chan_q       <= '0;
      beat_q       <= '0;
      m_valid_q    <= 1'b0;
      first_q      <= 1'b0;
      err_orphan_q <= 1'b0;
      err_sop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      chan_q       <= chan_d;
      beat_q       <= beat_d;
      m_valid_q    <= m_valid_d;
      first_q      <= first_d;
      err_orphan_q <= err_orphan_d;
      err_sop_q    <= err_sop_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_sop      = beat_q.sop;
  assign bus.m_eop      = beat_q.eop;
  assign bus.m_data     = beat_q.data;
  assign bus.m_chan     = chan_q;
  assign bus.err_orphan = err_orphan_q;
  assign bus.err_sop    = err_sop_q;

endmodule

// File: tb/tb_bitstream_pkt_arbiter.sv
// Directed bench for bitstream_pkt_arbiter: per-source beat queues drive the inputs, a scoreboard checks the output stream.
module tb_bitstream_pkt_arbiter;

  typedef struct packed {logic sop; logic eop; logic data;} sbeat_t;
  typedef struct packed {logic [1:0] chan; logic sop; logic eop; logic data;} exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bitstream_pkt_arbiter_if #(.N_SRC(4)) bus ();

  bitstream_pkt_arbiter #(.N_SRC(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sbeat_t srcq[4][$];
  exp_t   expq[$];
  int     out_cyc[$];
  int     checks = 0, errors = 0;
  int     cyc = 0, n_out = 0, orphan_cnt = 0, errsop_cnt = 0;
  logic   mr = 1'b1;
  logic [3:0] acc, sr_smp;
  logic [7:0] m_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pending();
    int p = expq.size();
    for (int i = 0; i < 4; i++) p += srcq[i].size();
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (srcq[i].size() != 0) begin
        bus.s_valid[i] = 1'b1;
        bus.s_sop[i]   = srcq[i][0].sop;
        bus.s_eop[i]   = srcq[i][0].eop;
        bus.s_data[i]  = srcq[i][0].data;
      end else begin
        bus.s_valid[i] = 1'b0;
        bus.s_sop[i]   = 1'b0;
        bus.s_eop[i]   = 1'b0;
        bus.s_data[i]  = 1'b0;
      end
    end
    bus.m_ready = mr;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc    = bus.s_valid & bus.s_ready;
    sr_smp = bus.s_ready;
    m_snap = {bus.m_valid, bus.m_chan, bus.m_sop, bus.m_eop, bus.m_data, bus.err_orphan, bus.err_sop};
    if (bus.err_orphan) orphan_cnt++;
    if (bus.err_sop) errsop_cnt++;
    if (reset_n && bus.m_valid && bus.m_ready) begin
      n_out++;
      out_cyc.push_back(cyc);
      chk("sb_has_entry", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("out_beat", 32'({bus.m_chan, bus.m_sop, bus.m_eop, bus.m_data}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic add_pkt(input int src, input int len, input logic [15:0] bits, input logic [15:0] xsop);
    sbeat_t b;
    exp_t   e;
    for (int k = 0; k < len; k++) begin
      b.sop  = (k == 0) || xsop[k];
      b.eop  = (k == len - 1);
      b.data = bits[k];
      srcq[src].push_back(b);
      e.chan = 2'(src);
      e.sop  = b.sop;
      e.eop  = b.eop;
      e.data = b.data;
      expq.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (pending() > 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain", 32'(pending()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    expq.delete();
    out_cyc.delete();
    mr = 1'b1;
    drive();
    tick();
    tick();
    reset_n    = 1'b1;
    n_out      = 0;
    orphan_cnt = 0;
    errsop_cnt = 0;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] mvh;
    sbeat_t     ob;
    int         k, n0, t0;

    // reset values
    do_reset();
    tick();
    chk("rst_m_valid", 32'(m_snap[7]), 32'd0);
    chk("rst_m_chan", 32'(m_snap[6:5]), 32'd0);
    chk("rst_m_sop", 32'(m_snap[4]), 32'd0);
    chk("rst_m_eop", 32'(m_snap[3]), 32'd0);
    chk("rst_m_data", 32'(m_snap[2]), 32'd0);
    chk("rst_err_orphan", 32'(m_snap[1]), 32'd0);
    chk("rst_err_sop", 32'(m_snap[0]), 32'd0);
    chk("rst_s_ready", 32'(sr_smp), 32'd0);

    // single source, 3 beats: m_valid in cycles 2..4 after presentation
    add_pkt(0, 3, 16'b101, 16'd0);
    drive();
    mvh = '0;
    for (int s = 0; s < 6; s++) begin
      tick();
      mvh[s] = m_snap[7];
      if (s == 0) chk("arb_cycle_sready0", 32'(sr_smp[0]), 32'd0);
    end
    chk("single_mvalid_seq", 32'(mvh), 32'b011100);
    chk("single_drained", 32'(pending()), 32'd0);

    // contention: 1 beats 2, then 2 beats 1's second packet
    do_reset();
    add_pkt(1, 2, 16'b10, 16'd0);
    add_pkt(2, 3, 16'b011, 16'd0);
    add_pkt(1, 2, 16'b01, 16'd0);
    drive();
    drain(60);
    chk("contention_outcount", 32'(out_cyc.size()), 32'd7);
    if (out_cyc.size() == 7) begin
      chk("back_to_back", 32'(out_cyc[1] - out_cyc[0]), 32'd1);
      chk("gap_after_eop_1", 32'(out_cyc[2] - out_cyc[1]), 32'd2);
      chk("gap_after_eop_2", 32'(out_cyc[5] - out_cyc[4]), 32'd2);
    end

    // backpressure: stall 4 cycles while beat 2 (data 1) sits on the output
    do_reset();
    add_pkt(0, 5, 16'b00101, 16'd0);
    drive();
    k = 0;
    while (n_out < 2 && k < 30) begin
      tick();
      k++;
    end
    mr = 1'b0;
    drive();
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("stall_hold", 32'(m_snap), 32'h84);
      chk("stall_sready", 32'(sr_smp[0]), 32'd0);
    end
    mr = 1'b1;
    drive();
    drain(40);
    chk("stall_outcount", 32'(n_out), 32'd5);

    // orphan beat while IDLE
    n0         = n_out;
    orphan_cnt = 0;
    ob.sop     = 1'b0;
    ob.eop     = 1'b0;
    ob.data    = 1'b1;
    srcq[3].push_back(ob);
    drive();
    tick();
    chk("orphan_sready3", 32'(sr_smp[3]), 32'd1);
    tick();
    tick();
    chk("orphan_pulse_count", 32'(orphan_cnt), 32'd1);
    chk("orphan_no_output", 32'(n_out - n0), 32'd0);
    chk("orphan_consumed", 32'(pending()), 32'd0);

    // sop inside a locked packet; source 1 competes but must wait for eop
    do_reset();
    add_pkt(0, 4, 16'b1001, 16'b0100);
    add_pkt(1, 2, 16'b11, 16'd0);
    drive();
    drain(50);
    chk("midsop_pulse_count", 32'(errsop_cnt), 32'd1);

    // reset while beat 2 of 5 is being presented
    do_reset();
    add_pkt(0, 5, 16'b10111, 16'd0);
    drive();
    k = 0;
    while (n_out < 1 && k < 30) begin
      tick();
      k++;
    end
    reset_n = 1'b0;
    srcq[0].delete();
    expq.delete();
    drive();
    tick();
    reset_n = 1'b1;
    out_cyc.delete();
    drive();
    tick();
    chk("midrst_outputs", 32'(m_snap), 32'd0);
    chk("midrst_s_ready", 32'(sr_smp), 32'd0);
    add_pkt(2, 2, 16'b10, 16'd0);
    drive();
    t0 = cyc;
    drain(40);
    chk("fresh_outcount", 32'(out_cyc.size()), 32'd2);
    if (out_cyc.size() != 0) chk("fresh_latency", 32'(out_cyc[0] - t0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
